// File: rtl/instr_fetch_feeder.sv
// Instruction fetch feeder: reads words from a synchronous ROM, issues them to the
// processor with a Run pulse, supplies MVI immediates and waits for Done under a watchdog.
module instr_fetch_feeder #(
    parameter int           AW      = 5,
    parameter logic [2:0]   MVI_OP  = 3'b001,
    parameter int           TIMEOUT = 16
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Go,
    input  logic          Stop,
    input  logic [15:0]   RomData,
    output logic [AW-1:0] RomAddr,
    output logic [15:0]   Din,
    output logic          Run,
    input  logic          Done,
    output logic          Busy,
    output logic          Timeout,
    output logic [15:0]   InstrCount,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        F_INS = 3'd1,
        L_INS = 3'd2,
        F_IMM = 3'd3,
        L_IMM = 3'd4,
        ISSUE = 3'd5,
        EXEC  = 3'd6
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t        state, next_state;
    logic [AW-1:0] pc_q;
    logic [15:0]   ir_q, imm_q, din_q, count_q;
    logic [7:0]    wd_q;
    logic          run_q, timeout_q, stop_pending;

    logic          go_start, load_ir, load_imm, pc_inc;
    logic          wd_clr, wd_inc, count_inc, set_timeout;
    logic [15:0]   din_d;

    // Run/Done handshake: Run is a single-cycle pulse that starts an instruction; the
    // processor answers with Done, which is only honoured while waiting in EXEC.
    always_comb begin
        next_state  = state;
        go_start    = 1'b0;
        load_ir     = 1'b0;
        load_imm    = 1'b0;
        pc_inc      = 1'b0;
        wd_clr      = 1'b0;
        wd_inc      = 1'b0;
        count_inc   = 1'b0;
        set_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (Go) begin
                    go_start   = 1'b1;
                    next_state = F_INS;
                end
            end
            F_INS: next_state = L_INS;
            L_INS: begin
                load_ir    = 1'b1;
                pc_inc     = 1'b1;
                next_state = (RomData[8:6] == MVI_OP) ? F_IMM : ISSUE;
            end
            F_IMM: next_state = L_IMM;
            L_IMM: begin
                load_imm   = 1'b1;
                pc_inc     = 1'b1;
                next_state = ISSUE;
            end
            ISSUE: begin
                wd_clr     = 1'b1;
                next_state = EXEC;
            end
            EXEC: begin
                // Done takes priority over a watchdog expiring in the same cycle.
                if (Done) begin
                    count_inc  = 1'b1;
                    next_state = (stop_pending || Stop) ? IDLE : F_INS;
                end else if (wd_q == WD_LAST) begin
                    set_timeout = 1'b1;
                    next_state  = IDLE;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Din is registered: it takes the word being issued, then the operand seen during EXEC.
    always_comb begin
        din_d = din_q;
        if (next_state == ISSUE) begin
            din_d = load_ir ? RomData : ir_q;
        end else if (next_state == EXEC) begin
            din_d = (ir_q[8:6] == MVI_OP) ? imm_q : ir_q;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state        <= IDLE;
            pc_q         <= '0;
            ir_q         <= '0;
            imm_q        <= '0;
            din_q        <= '0;
            run_q        <= 1'b0;
            timeout_q    <= 1'b0;
            count_q      <= '0;
            wd_q         <= '0;
            stop_pending <= 1'b0;
        end else begin
            state <= next_state;
            din_q <= din_d;
            run_q <= (next_state == ISSUE);
            if (load_ir)   ir_q    <= RomData;
            if (load_imm)  imm_q   <= RomData;
            if (pc_inc)    pc_q    <= pc_q + AW'(1);
            if (count_inc) count_q <= count_q + 16'd1;
            if (wd_clr)        wd_q <= '0;
            else if (wd_inc)   wd_q <= wd_q + 8'd1;
            if (go_start)          timeout_q <= 1'b0;
            else if (set_timeout)  timeout_q <= 1'b1;
            // A stop request is remembered until the feeder drops back to IDLE.
            if (go_start || (state != IDLE && next_state == IDLE)) stop_pending <= 1'b0;
            else if (state != IDLE && Stop)                        stop_pending <= 1'b1;
        end
    end

    assign RomAddr    = pc_q;
    assign Din        = din_q;
    assign Run        = run_q;
    assign Busy       = (state != IDLE);
    assign Timeout    = timeout_q;
    assign InstrCount = count_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_instr_fetch_feeder.sv
// Bench for instr_fetch_feeder: a ROM model and a processor model driven step by step,
// with expectations derived from an instruction-level model of PC, counter and flags.
module tb_instr_fetch_feeder;

    localparam int AW      = 5;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 1 << AW;

    logic          Clock = 1'b0;
    logic          Resetn, Go, Stop, Done;
    logic [15:0]   RomData;
    logic [AW-1:0] RomAddr;
    logic [15:0]   Din, InstrCount;
    logic          Run, Busy, Timeout;
    logic [2:0]    dbg_state;

    logic [15:0] rom [0:DEPTH-1];

    int          tests = 0;
    int          fails = 0;
    int          m_pc;
    logic [15:0] m_count;
    bit          m_busy, m_timeout, m_stop;

    instr_fetch_feeder #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Resetn(Resetn), .Go(Go), .Stop(Stop),
        .RomData(RomData), .RomAddr(RomAddr), .Din(Din), .Run(Run),
        .Done(Done), .Busy(Busy), .Timeout(Timeout),
        .InstrCount(InstrCount), .dbg_state(dbg_state)
    );

    always #5 Clock = ~Clock;

    // Synchronous ROM, one cycle of read latency.
    always @(posedge Clock) RomData <= rom[RomAddr];

    initial begin
        #200000;
        $display("FAIL global_timeout: observed state %0d still running, required finish", dbg_state);
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rand_word(input bit mvi);
        logic [15:0] w;
        logic [2:0]  op;
        w = 16'($urandom);
        if (mvi) begin
            op = 3'b001;
        end else begin
            op = 3'($urandom_range(0, 6));
            if (op == 3'b001) op = 3'b111;
        end
        w[8:6] = op;
        return w;
    endfunction

    task automatic start_run();
        check("run_idle", Run, 0);
        check("busy_idle", Busy, 0);
        Go = 1'b1;
        tick();
        Go = 1'b0;
        m_timeout = 0;
        m_stop    = 0;
        m_busy    = 1;
        check("timeout_cleared", Timeout, 0);
        check("busy_after_go", Busy, 1);
    endtask

    // One instruction from its fetch cycle to completion.
    // done_at: EXEC cycle (1-based) carrying Done, 0 = never. stop_phase: 1 = L_INS, 2 = ISSUE.
    task automatic do_instr(input int done_at, input int stop_phase);
        logic [15:0] w, imm, exp_din;
        bit          mvi, done_seen;
        check("addr_fetch", RomAddr, m_pc);
        check("run_fetch", Run, 0);
        Go = 1'($urandom_range(0, 1));
        tick();
        check("run_load", Run, 0);
        if (stop_phase == 1) begin
            Stop   = 1'b1;
            m_stop = 1;
        end
        w    = rom[m_pc];
        mvi  = (w[8:6] == 3'b001);
        m_pc = (m_pc + 1) % DEPTH;
        tick();
        Stop = 1'b0;
        Go   = 1'b0;
        imm  = w;
        if (mvi) begin
            check("addr_imm", RomAddr, m_pc);
            tick();
            imm  = rom[m_pc];
            m_pc = (m_pc + 1) % DEPTH;
            tick();
        end
        exp_din = mvi ? imm : w;
        check("run_issue", Run, 1);
        check("din_issue", Din, w);
        if (stop_phase == 2) begin
            Stop   = 1'b1;
            m_stop = 1;
        end
        tick();
        Stop = 1'b0;
        done_seen = 0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            check("run_exec", Run, 0);
            check("din_exec", Din, exp_din);
            if (k == done_at) Done = 1'b1;
            tick();
            Done = 1'b0;
            if (k == done_at) begin
                done_seen = 1;
                break;
            end
        end
        if (done_seen) begin
            m_count = m_count + 16'd1;
            m_busy  = !m_stop;
        end else begin
            m_timeout = 1;
            m_busy    = 0;
        end
        if (!m_busy) m_stop = 0;
        check("instr_count", InstrCount, m_count);
        check("pc_after", RomAddr, m_pc);
        check("busy_after", Busy, m_busy);
        check("timeout_flag", Timeout, m_timeout);
        check("run_after", Run, 0);
    endtask

    task automatic step(input int done_at, input int stop_phase);
        if (!m_busy) start_run();
        do_instr(done_at, stop_phase);
    endtask

    initial begin
        Resetn = 1'b0;
        Go     = 1'b0;
        Stop   = 1'b0;
        Done   = 1'b0;
        for (int i = 0; i < DEPTH; i++) rom[i] = rand_word($urandom_range(0, 3) == 0);
        rom[0]  = 16'h0011;
        rom[1]  = rand_word(0);
        rom[2]  = rand_word(0);
        rom[3]  = 16'h0048;
        rom[4]  = 16'h00A5;
        for (int i = 5; i <= 8; i++) rom[i] = rand_word(0);
        rom[30] = rand_word(0);
        rom[31] = 16'h0040;
        m_pc = 0; m_count = '0; m_busy = 0; m_timeout = 0; m_stop = 0;

        // Reset values.
        #12;
        check("rst_run", Run, 0);
        check("rst_busy", Busy, 0);
        check("rst_din", Din, 0);
        check("rst_addr", RomAddr, 0);
        check("rst_count", InstrCount, 0);
        check("rst_timeout", Timeout, 0);
        Resetn = 1'b1;
        tick();

        // Stop and Done are ignored while idle.
        Stop = 1'b1;
        Done = 1'b1;
        tick();
        tick();
        Stop = 1'b0;
        Done = 1'b0;
        check("idle_busy", Busy, 0);
        check("idle_count", InstrCount, 0);
        check("idle_run", Run, 0);

        // Plain move, Done in first EXEC cycle, Stop during ISSUE.
        step(1, 2);
        // Two fillers to reach the MVI at address 3, then MVI with its immediate.
        step($urandom_range(1, TIMEOUT), 0);
        step($urandom_range(1, TIMEOUT), 0);
        step(3, 0);
        // Processor never answers: watchdog expires.
        step(0, 0);
        // Restart clears Timeout; Stop in L_INS finishes that instruction and halts.
        step(2, 0);
        step(5, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_run", Run, 0);
            check("halt_busy", Busy, 0);
        end
        // Done on the very last watchdog cycle wins.
        step(TIMEOUT, 0);

        // Random traffic until the PC reaches the last address, then the wrapping MVI.
        rom[0] = 16'h1234;
        for (int n = 0; n < 40 && m_pc != DEPTH - 1; n++) begin
            step($urandom_range(0, TIMEOUT), $urandom_range(0, 2));
        end
        if (!m_busy) start_run();
        check("reach_last_addr", RomAddr, DEPTH - 1);
        do_instr($urandom_range(1, TIMEOUT), 1);

        // Asynchronous reset during EXEC.
        start_run();
        tick();
        tick();
        tick();
        tick();
        Resetn = 1'b0;
        #1;
        m_pc = 0; m_count = '0; m_busy = 0; m_timeout = 0; m_stop = 0;
        check("arst_run", Run, 0);
        check("arst_busy", Busy, 0);
        check("arst_addr", RomAddr, m_pc);
        check("arst_count", InstrCount, m_count);
        check("arst_timeout", Timeout, 0);
        #2;
        Resetn = 1'b1;
        Done   = 1'b1;
        tick();
        Done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("post_rst_count", InstrCount, m_count);
            check("post_rst_busy", Busy, 0);
            check("post_rst_run", Run, 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
